// File: rtl/riscv_pkg.sv
// riscv_pkg: ALU op codes, opcodes, funct7 values and operand-select types shared by decode and ALU
package riscv_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic [1:0] {A_ZERO, A_RS1, A_PC} sel_a_t;
  typedef enum logic [2:0] {B_ZERO, B_RS2, B_IMM_I, B_SHAMT, B_IMM_U} sel_b_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps opcode/funct fields to alu_op, illegal flag and operand selects
module alu_op_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_op,
  output logic       illegal,
  output sel_a_t     sel_a,
  output sel_b_t     sel_b
);
  logic       f7_base, f7_alt, is_op, is_imm, is_shift, slt;
  logic [2:0] f3_op;
  assign f7_base  = funct7 == F7_BASE;
  assign f7_alt   = funct7 == F7_ALT;
  assign is_op    = opcode == OPC_OP;
  assign is_imm   = opcode == OPC_OP_IMM;
  assign is_shift = funct3 == 3'b001 || funct3 == 3'b101;
  assign slt      = funct3 == 3'b010 || funct3 == 3'b011;
  always_comb begin
    f3_op = ALU_ADD;
    case (funct3)
      3'b000: f3_op = (is_op && f7_alt) ? ALU_SUB : ALU_ADD;
      3'b001: f3_op = ALU_SLL;
      3'b100: f3_op = ALU_XOR;
      3'b101: f3_op = f7_alt ? ALU_SRA : ALU_SRL;
      3'b110: f3_op = ALU_OR;
      3'b111: f3_op = ALU_AND;
      default: f3_op = ALU_ADD;
    endcase
  end
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    sel_a   = A_ZERO;
    sel_b   = B_ZERO;
    case (opcode)
      OPC_OP: begin
        alu_op  = f3_op;
        sel_a   = A_RS1;
        sel_b   = B_RS2;
        illegal = slt || !(f7_base || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        alu_op  = f3_op;
        sel_a   = A_RS1;
        sel_b   = is_shift ? B_SHAMT : B_IMM_I;
        // non-shift immediates carry payload in funct7 bits, so only shifts check it
        illegal = slt || (funct3 == 3'b001 && !f7_base) || (funct3 == 3'b101 && !f7_base && !f7_alt);
      end
      OPC_LUI: sel_b = B_IMM_U;
      OPC_AUIPC: begin
        sel_a = A_PC;
        sel_b = B_IMM_U;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_op = ALU_ADD;
      sel_a  = A_ZERO;
      sel_b  = B_ZERO;
    end
  end
  logic unused;
  assign unused = is_imm;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/forward operands and register them for the ALU behind a valid/ready handshake
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            fwd_ex_valid,
  input  logic [4:0]      fwd_ex_rd,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_wb_valid,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] src_a,
  output logic [XLEN-1:0] src_b,
  output logic [2:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);
  logic [2:0]      dec_op;
  logic            dec_ill, accept;
  sel_a_t          sel_a;
  sel_b_t          sel_b;
  logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b, imm_i, imm_u, shamt;
  alu_op_decode u_dec (
    .opcode (instr[6:0]),
    .funct3 (instr[14:12]),
    .funct7 (instr[31:25]),
    .alu_op (dec_op),
    .illegal(dec_ill),
    .sel_a  (sel_a),
    .sel_b  (sel_b)
  );
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] r, input logic [XLEN-1:0] rf);
    return (r == 5'd0) ? '0 :
           (fwd_ex_valid && fwd_ex_rd == r) ? fwd_ex_data :
           (fwd_wb_valid && fwd_wb_rd == r) ? fwd_wb_data : rf;
  endfunction
  assign rs1_val = fwd(instr[19:15], rs1_data);
  assign rs2_val = fwd(instr[24:20], rs2_data);
  assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u   = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign shamt   = {{(XLEN-5){1'b0}}, instr[24:20]};
  always_comb begin
    op_a = (sel_a == A_RS1) ? rs1_val : (sel_a == A_PC) ? pc : '0;
    op_b = (sel_b == B_RS2) ? rs2_val : (sel_b == B_IMM_I) ? imm_i :
           (sel_b == B_SHAMT) ? shamt : (sel_b == B_IMM_U) ? imm_u : '0;
  end
  assign in_ready = flush || !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      src_a     <= '0;
      src_b     <= '0;
      alu_op    <= ALU_ADD;
      rd        <= '0;
      rd_we     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= accept || (out_valid && !out_ready && !flush);
      if (accept) begin
        src_a   <= op_a;
        src_b   <= op_b;
        alu_op  <= dec_op;
        rd      <= instr[11:7];
        rd_we   <= !dec_ill && instr[11:7] != 5'd0;
        illegal <= dec_ill;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a spec-level model
module tb_id_ex_stage;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [31:0] instr = 0, pc = 0, rs1_data = 0, rs2_data = 0, src_a, src_b;
  logic        fwd_ex_valid = 0, fwd_wb_valid = 0, rd_we, illegal;
  logic [4:0]  fwd_ex_rd = 0, fwd_wb_rd = 0, rd;
  logic [31:0] fwd_ex_data = 0, fwd_wb_data = 0;
  logic [2:0]  alu_op;
  int          total = 0, passed = 0;
  typedef struct packed {
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        we, ill;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd),
    .fwd_ex_data(fwd_ex_data), .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd),
    .fwd_wb_data(fwd_wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .src_a(src_a), .src_b(src_b), .alu_op(alu_op), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [31:0] rv(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 0;
    if (fwd_ex_valid && fwd_ex_rd == r) return fwd_ex_data;
    if (fwd_wb_valid && fwd_wb_rd == r) return fwd_wb_data;
    return rf;
  endfunction
  function automatic exp_t model();
    exp_t e = '0;
    logic [6:0] opc = instr[6:0], f7 = instr[31:25];
    int f3 = int'(instr[14:12]);
    bit is_op = opc == 7'h33, is_imm = opc == 7'h13, ok = 0, base = f7 == 0, alt = f7 == 7'h20;
    e.rd = instr[11:7];
    if (opc == 7'h37 || opc == 7'h17) begin
      ok = 1;
      e.a = (opc == 7'h17) ? pc : 0;
      e.b = instr & 32'hFFFFF000;
    end else if (is_op || is_imm) begin
      e.a = rv(instr[19:15], rs1_data);
      if (is_op) e.b = rv(instr[24:20], rs2_data);
      else if (f3 == 1 || f3 == 5) e.b = 32'(instr[24:20]);
      else e.b = 32'(int'($signed(instr[31:20])));
      case (f3)
        0: begin e.op = (is_op && alt) ? 1 : 0; ok = is_imm || base || alt; end
        1: begin e.op = 5; ok = base; end
        4: begin e.op = 4; ok = is_imm || base; end
        5: begin e.op = alt ? 7 : 6; ok = base || alt; end
        6: begin e.op = 3; ok = is_imm || base; end
        7: begin e.op = 2; ok = is_imm || base; end
        default: ok = 0;
      endcase
    end
    if (!ok) begin
      e.a = 0; e.b = 0; e.op = 0; e.ill = 1;
    end
    e.we = ok && e.rd != 0;
    return e;
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [6:0] opc, f7;
    case ($urandom_range(0, 5))
      0, 1: opc = 7'h33;
      2, 3: opc = 7'h13;
      4: opc = ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17;
      default: opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0, 1: f7 = 0;
      2: f7 = 7'h20;
      3: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), opc};
  endfunction
  task automatic tick();
    bit rdy;
    #1;
    rdy = q.size() == 0 || out_ready || flush;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("src_a", src_a, q[0].a);
      chk("src_b", src_b, q[0].b);
      chk("alu_op", 32'(alu_op), 32'(q[0].op));
      chk("rd", 32'(rd), 32'(q[0].rd));
      chk("rd_we", 32'(rd_we), 32'(q[0].we));
      chk("illegal", 32'(illegal), 32'(q[0].ill));
    end
    if (flush) q.delete();
    else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) q.push_back(model());
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic issue(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    instr = i; rs1_data = r1; rs2_data = r2; pc = $urandom;
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_src_a"}, src_a, 0);
    chk({tag, "_src_b"}, src_b, 0);
    chk({tag, "_op"}, 32'(alu_op), 0);
    chk({tag, "_rd"}, 32'(rd), 0);
    chk({tag, "_we"}, 32'(rd_we), 0);
    chk({tag, "_ill"}, 32'(illegal), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1;
    @(negedge clk);
    issue(32'h003100B3, 5, 7);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_a", src_a, 5);
    chk("add_b", src_b, 7);
    chk("add_op", 32'(alu_op), 0);
    chk("add_rd", 32'(rd), 1);
    chk("add_we", 32'(rd_we), 1);
    issue(32'h4020D093, 32'h8000_0000, 3);
    chk("srai_op", 32'(alu_op), 7);
    chk("srai_b", src_b, 2);
    issue(32'h40208033, 9, 4);
    chk("sub_op", 32'(alu_op), 1);
    chk("sub_we", 32'(rd_we), 0);
    fwd_ex_valid = 1; fwd_ex_rd = 2; fwd_ex_data = 32'hAA;
    fwd_wb_valid = 1; fwd_wb_rd = 2; fwd_wb_data = 32'hBB;
    issue(32'h003102B3, 32'h11, 32'h22);
    chk("fwd_ex_wins", src_a, 32'hAA);
    fwd_ex_rd = 0; fwd_wb_rd = 0;
    issue(32'h003002B3, 32'h11, 32'h22);
    chk("fwd_x0", src_a, 0);
    fwd_ex_valid = 0; fwd_wb_valid = 0;
    issue(32'h0020A0B3, 1, 2);
    chk("slt_ill", 32'(illegal), 1);
    chk("slt_we", 32'(rd_we), 0);
    chk("slt_op", 32'(alu_op), 0);
    issue(32'h003100B3, 1, 2);
    instr = 32'h0020C1B3; in_valid = 1; out_ready = 0;
    repeat (3) tick();
    chk("stall_ready", 32'(in_ready), 0);
    out_ready = 1;
    repeat (2) tick();
    in_valid = 0;
    tick();
    issue(32'h003100B3, 3, 4);
    out_ready = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_valid", 32'(out_valid), 0);
    for (int c = 0; c < 120; c++) begin
      instr = rand_instr(); pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
      in_valid = $urandom_range(0, 3) != 0; out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      fwd_ex_valid = $urandom_range(0, 1) == 1; fwd_ex_rd = 5'($urandom_range(0, 3));
      fwd_ex_data = $urandom;
      fwd_wb_valid = $urandom_range(0, 1) == 1; fwd_wb_rd = 5'($urandom_range(0, 3));
      fwd_wb_data = $urandom;
      tick();
    end
    flush = 0;
    issue(32'h003100B3, 32'h1234, 32'h5678);
    out_ready = 0;
    #3 rst_n = 0;
    #1 chk_reset("async_rst");
    q.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
